// File: rtl/reg_share_pkg.sv
// reg_share_pkg
//   Shared types and helpers for the register-sharing round-robin arbiter.
//   - NREQ_MAX : largest supported requester count
//   - owner_t  : writer index wide enough for NREQ_MAX requesters
//   - rr_next  : priority pointer update after a grant
package reg_share_pkg;

    localparam int NREQ_MAX = 16;
    localparam int OWNER_W  = $clog2(NREQ_MAX);

    typedef logic [OWNER_W-1:0] owner_t;

    // The pointer moves to the slot just after the winner, wrapping at nreq
    // rather than at the power of two. A winner index outside the active
    // range means nobody was granted, so the pointer is left unchanged.
    function automatic owner_t rr_next(input owner_t ptr, input owner_t winner, input int nreq);
        if (int'(winner) >= nreq) begin
            return ptr;
        end else if (int'(winner) == nreq - 1) begin
            return '0;
        end else begin
            return winner + owner_t'(1);
        end
    endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. It finds the first set bit of i_valid,
//   starting the scan at i_ptr and wrapping modulo NREQ.
//   Ports:
//     i_valid  [NREQ-1:0]  request vector
//     i_ptr    [PW-1:0]    index that has the highest priority this cycle
//     o_grant  [NREQ-1:0]  one-hot grant, or zero when nothing is valid
//     o_winner [PW-1:0]    binary index of the granted requester
//     o_any                at least one request is valid
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_winner,
    output logic            o_any
);

    logic [NREQ-1:0]   w_mask;
    logic [2*NREQ-1:0] w_dbl;
    int                w_sel;

    // w_mask keeps only the requesters at or above the pointer.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
        assign w_mask[gi] = (PW'(gi) >= i_ptr);
    end

    // The low copy holds the requesters at or above ptr. The high copy is the
    // unmasked vector and supplies the wrap-around candidates. The lowest set
    // bit of the pair, taken modulo NREQ, is the round-robin winner.
    assign w_dbl = {i_valid, i_valid & w_mask};
    assign o_any = |i_valid;

    always_comb begin
        w_sel    = 0;
        o_grant  = '0;
        // Scan downwards so that the lowest set bit is the last one written.
        for (int j = 2*NREQ - 1; j >= 0; j--) begin
            if (w_dbl[j]) begin
                w_sel = j;
            end
        end
        if (w_sel >= NREQ) begin
            w_sel = w_sel - NREQ;
        end
        o_winner = PW'(w_sel);
        if (o_any) begin
            o_grant[o_winner] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//   Shares one WIDTH-bit register between NREQ writers. At most one write is
//   accepted per cycle, and the writers are served in round-robin order.
//   Ports:
//     aclk, srst        clock and synchronous active-high reset
//     en                arbitration enable; 0 holds all grants low, ptr frozen
//     req_valid[NREQ]   write requests
//     req_data          write data, requester i at [i*WIDTH +: WIDTH]
//     req_ready[NREQ]   grants, one-hot or zero (combinational)
//     q                 shared register value
//     q_owner           index of the last accepted writer
//     q_upd             high for one cycle after each accepted write
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int              NREQ    = 4,
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                    aclk,
    input  logic                    srst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        q,
    output logic [$clog2(NREQ)-1:0] q_owner,
    output logic                    q_upd
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_owner;
    logic             r_upd;

    logic [NREQ-1:0]  w_grant;
    logic [PW-1:0]    w_win;
    logic             w_any;
    logic             w_go;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // A grant is issued only when arbitration is enabled and reset is low.
    // Reset blocks the handshake, so no write can coincide with a reset edge.
    assign w_go      = w_any & en & ~srst;
    assign req_ready = w_go ? w_grant : '0;

    always_ff @(posedge aclk) begin
        if (srst) begin
            r_q     <= RST_VAL;
            r_owner <= '0;
            r_upd   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_go) begin
            r_q     <= req_data[w_win*WIDTH +: WIDTH];
            r_owner <= w_win;
            r_upd   <= 1'b1;
            r_ptr   <= PW'(rr_next(owner_t'(r_ptr), owner_t'(w_win), NREQ));
        end else begin
            r_upd   <= 1'b0;
        end
    end

    assign q       = r_q;
    assign q_owner = r_owner;
    assign q_upd   = r_upd;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter
//   Directed vectors with hand-computed expectations. Two instances are used:
//   NREQ=4 (RST_VAL=8'h3C) and NREQ=3, which covers the pointer wrap case.
//   Inputs are driven 1 ns after the rising edge. Combinational outputs are
//   checked 1 ns after that, and registered outputs after the next edge.
module tb_reg_share_arbiter;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    // NREQ=4 instance
    logic        srst4, en4;
    logic [3:0]  v4;
    logic [31:0] d4;
    logic [3:0]  rdy4;
    logic [7:0]  q4;
    logic [1:0]  own4;
    logic        upd4;

    // NREQ=3 instance
    logic        srst3, en3;
    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  rdy3;
    logic [7:0]  q3;
    logic [1:0]  own3;
    logic        upd3;

    int n_vec = 0;
    int n_bad = 0;

    reg_share_arbiter #(.NREQ(4), .WIDTH(8), .RST_VAL(8'h3C)) dut4 (
        .aclk      (aclk),
        .srst      (srst4),
        .en        (en4),
        .req_valid (v4),
        .req_data  (d4),
        .req_ready (rdy4),
        .q         (q4),
        .q_owner   (own4),
        .q_upd     (upd4)
    );

    reg_share_arbiter #(.NREQ(3), .WIDTH(8), .RST_VAL(8'h00)) dut3 (
        .aclk      (aclk),
        .srst      (srst3),
        .en        (en3),
        .req_valid (v3),
        .req_data  (d3),
        .req_ready (rdy3),
        .q         (q3),
        .q_owner   (own3),
        .q_upd     (upd3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("  ok %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Check the registered outputs of the NREQ=4 instance.
    task automatic chk4(input string tag, input logic [7:0] eq, input logic [1:0] eo, input logic eu);
        chk({tag, ".q"},     32'(q4),   32'(eq));
        chk({tag, ".owner"}, 32'(own4), 32'(eo));
        chk({tag, ".upd"},   32'(upd4), 32'(eu));
    endtask

    initial begin
        int order4 [5];
        int order3 [4];
        order4 = '{0, 1, 2, 3, 0};
        order3 = '{0, 1, 2, 0};

        srst4 = 1'b1; en4 = 1'b1; v4 = 4'b1111; d4 = 32'h0;
        srst3 = 1'b1; en3 = 1'b1; v3 = 3'b000;  d3 = 24'h0;

        // Reset held for 3 edges with every requester valid: no grants.
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("rst_ready%0d", c), 32'(rdy4), 32'h0);
            tick();
        end
        srst4 = 1'b0; v4 = 4'b0000;
        settle();
        chk4("after_rst", 8'h3C, 2'd0, 1'b0);

        // Single requester 2 with data A5.
        v4 = 4'b0100; d4 = 32'h00A5_0000;
        settle();
        chk("single.ready", 32'(rdy4), 32'h4);
        tick();
        v4 = 4'b0000;
        chk4("single.wr", 8'hA5, 2'd2, 1'b1);
        tick();
        chk4("single.idle", 8'hA5, 2'd2, 1'b0);

        // Reset to bring ptr back to 0, then full contention.
        srst4 = 1'b1;
        tick();
        srst4 = 1'b0; v4 = 4'b1111; d4 = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("full%0d.ready", k), 32'(rdy4), 32'(1 << order4[k]));
            tick();
            chk4($sformatf("full%0d", k), 8'(8'h10 + order4[k]), 2'(order4[k]), 1'b1);
        end

        // Enable freeze. The pointer is 1 after the last grant to requester 0.
        en4 = 1'b0; v4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("frz%0d.ready", k), 32'(rdy4), 32'h0);
            tick();
            chk4($sformatf("frz%0d", k), 8'h10, 2'd0, 1'b0);
        end
        en4 = 1'b1;
        settle();
        chk("resume.ready", 32'(rdy4), 32'h2);
        tick();
        chk4("resume", 8'h11, 2'd1, 1'b1);
        settle();
        chk("resume2.ready", 32'(rdy4), 32'h8);
        tick();
        chk4("resume2", 8'h13, 2'd3, 1'b1);

        // Reset asserted in the middle of full contention.
        srst4 = 1'b1; v4 = 4'b0000;
        tick();
        srst4 = 1'b0; v4 = 4'b1111;
        settle();
        chk("mid.c1.ready", 32'(rdy4), 32'h1);
        tick();
        chk4("mid.c1", 8'h10, 2'd0, 1'b1);
        settle();
        chk("mid.c2.ready", 32'(rdy4), 32'h2);
        tick();
        chk4("mid.c2", 8'h11, 2'd1, 1'b1);
        srst4 = 1'b1;
        settle();
        chk("mid.rst.ready", 32'(rdy4), 32'h0);
        tick();
        chk4("mid.rst", 8'h3C, 2'd0, 1'b0);
        srst4 = 1'b0;
        settle();
        chk("mid.after.ready", 32'(rdy4), 32'h1);
        tick();
        chk4("mid.after", 8'h10, 2'd0, 1'b1);
        v4 = 4'b0000;

        // NREQ=3 wrap: requester 2 alone wins first, then 0 and 1 follow.
        srst3 = 1'b0; v3 = 3'b100; d3 = 24'h22_2120;
        settle();
        chk("w3.first.ready", 32'(rdy3), 32'h4);
        tick();
        chk("w3.first.q", 32'(q3), 32'h22);
        chk("w3.first.owner", 32'(own3), 32'd2);
        v3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("w3.%0d.ready", k), 32'(rdy3), 32'(1 << order3[k]));
            tick();
            chk($sformatf("w3.%0d.q", k), 32'(q3), 32'(8'h20 + order3[k]));
            chk($sformatf("w3.%0d.owner", k), 32'(own3), 32'(order3[k]));
            chk($sformatf("w3.%0d.upd", k), 32'(upd3), 32'h1);
        end
        v3 = 3'b000;
        tick();
        chk("w3.idle.upd", 32'(upd3), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
